popcnt_ctrl: RTL and testbench
==============================

# popcnt_ctrl

Multi-cycle sequencer that computes the population count of a 32-bit operand by feeding one byte per cycle through a single 8-bit ones-counter and accumulating the partial sums. It sits beside the ALU/MDU as an optional execution unit. It uses a start/busy/done handshake so the pipeline can stall while it runs. Two modes: count ones, or count zeros.

## Interface
- No parameters. Operand width is 32, byte width 8, result width 6; all are fixed constants.
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- op  in  1  mode, sampled with start: 0 = count ones, 1 = count zeros
- A  in  32  operand, sampled with start
- clr  in  1  synchronous abort of an in-flight operation
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when result is updated
- result  out  6  last completed count, range 0..32

## Operation
- States: IDLE, RUN. Internal registers:
  - opnd[31:0]
  - mode
  - idx[1:0] (byte index)
  - acc[5:0]
- IDLE + start & !clr:
  - opnd<=A, mode<=op, idx<=0, acc<=0
  - go RUN
- IDLE + clr: stay IDLE; start is ignored that cycle.
- RUN, each cycle:
  - byte = opnd[8*idx +: 8], inverted when mode=1
  - acc <= acc + count(byte), where count is 0..8, zero-extended to 6 bits
  - idx <= idx+1
- RUN with idx==3:
  - result <= acc + count(byte3)
  - done <= 1
  - go IDLE
- RUN + clr:
  - go IDLE; acc and idx are discarded
  - result unchanged, no done pulse
  - clr has priority over the final accumulation.
- start while busy: ignored. The operand and op are not re-sampled.
- Width rule: maximum sum is 32, which fits in 6 bits. No overflow handling is required.
- busy = (state==RUN), combinational from the state register.
- done is a registered pulse, high exactly one cycle, and is cleared the cycle after it is set.
- result holds its value until the next completed operation or reset.
- Reset (any state, including mid-RUN):
  - state=IDLE, busy=0, done=0, result=0
  - acc=0, idx=0, opnd=0, mode=0

## Timing
- Accepting edge = end of cycle t, when start is high in IDLE.
- busy is high in cycles t+1..t+4; byte0..byte3 are processed in cycles t+1..t+4, LSB first.
- done is high in cycle t+5, and result is valid from t+5 onward.
- Latency from start to done is 5 cycles. Throughput is one operation per 5 cycles.
- State is IDLE in cycle t+5, so a start in the done cycle is accepted; its done arrives at t+10.
- clr sampled in cycle t+k (1≤k≤4) gives busy=0 from t+k+1, with no done.
- reset has priority over clr and start. clr has priority over start.

## Structure
- Shared header (popcnt_defs.v) holds:
  - `define state encodings (IDLE=1'b0, RUN=1'b1)
  - op codes (OP_ONES=0, OP_ZEROS=1)
  - widths (WORD=32, BYTE=8, CNT=6)
- One sub-module, byte_popcnt: combinational 8-bit in, 4-bit count out (0..8). It is instantiated once, and its input is muxed by idx and mode.
- The FSM, accumulator and output registers live in popcnt_ctrl.

## Test plan
- Reset, then start A=32'hFFFF_FFFF op=0: busy high 4 cycles, done at t+5, result=32.
- A=32'h0000_0001 op=1: result=31. A=32'h0000_0000 op=0: result=0, done still pulses.
- A=32'h8040_2010 op=0, plus a second start with A=32'hFFFF_FFFF at t+2: second start is ignored, result=4, single done.
- A=32'h0F0F_0F0F op=0 with clr at t+2: busy low from t+3, no done, result keeps its prior value. A new start at t+3 completes normally (result=16).
- Back-to-back operations:
  - start A=32'h0000_00FF op=0; result=8 at t+5.
  - start again in the done cycle with A=32'hF000_0000 op=1; result=28 at t+10.
- reset at t+3 mid-RUN: next cycle busy=0, done=0, result=0. start in the same cycle as reset is not accepted.

Source files
------------

// File: rtl/popcnt_ctrl_pkg.sv
// Shared types and constants for the byte-serial population count unit.
// Widths, state encoding and mode codes.
package popcnt_ctrl_pkg;

  localparam int WORD = 32;
  localparam int BYTE = 8;
  localparam int CNT  = 6;

  localparam logic OP_ONES  = 1'b0;
  localparam logic OP_ZEROS = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/popcnt_ctrl_byte_popcnt.sv
// Combinational ones-counter for one byte.
// Output range is 0..8.
module byte_popcnt
  import popcnt_ctrl_pkg::*;
(
  input  logic [BYTE-1:0] in,
  output logic [3:0]      cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < BYTE; i++)
      cnt = cnt + {3'b000, in[i]};
  end

endmodule

// File: rtl/popcnt_ctrl.sv
// Multi-cycle popcount sequencer: one byte per cycle, LSB first.
// start/busy/done handshake, count-ones or count-zeros mode.
module popcnt_ctrl
  import popcnt_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            op,
  input  logic [WORD-1:0] A,
  input  logic            clr,
  output logic            busy,
  output logic            done,
  output logic [CNT-1:0]  result
);

  state_t          state;
  state_t          state_nxt;
  logic [WORD-1:0] opnd;
  logic            mode;
  logic [1:0]      idx;
  logic [CNT-1:0]  acc;
  logic [BYTE-1:0] sel_byte;
  logic [3:0]      cnt;
  logic [CNT-1:0]  sum;
  logic            last;

  assign sel_byte = opnd[{idx, 3'b000} +: BYTE] ^ {BYTE{mode}};
  assign sum      = acc + {2'b00, cnt};
  assign last     = (idx == 2'd3);

  byte_popcnt u_byte (
    .in  (sel_byte),
    .cnt (cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start && !clr) state_nxt = RUN;
      RUN:  if (clr || last)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  // clr wins over the final accumulation, so result only moves on a clean finish
  always_ff @(posedge clk) begin
    if (reset) begin
      opnd   <= '0;
      mode   <= OP_ONES;
      idx    <= '0;
      acc    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !clr) begin
            opnd <= A;
            mode <= op;
            idx  <= '0;
            acc  <= '0;
          end
        end
        RUN: begin
          if (clr) begin
            idx <= '0;
            acc <= '0;
          end else begin
            acc <= sum;
            idx <= idx + 2'd1;
            if (last) begin
              result <= sum;
              done   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_popcnt_ctrl.sv
// Directed bench for popcnt_ctrl: vector table plus
// hand-written abort, ignore, back-to-back and reset sequences.
module tb_popcnt_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] A;
  logic        clr;
  logic        busy;
  logic        done;
  logic [5:0]  result;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic        op;
    int          exp;
  } vec_t;

  vec_t vecs[8];

  popcnt_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .A      (A),
    .clr    (clr),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issues start in the current cycle; returns in the done cycle (t+5).
  task automatic run_op(input logic [31:0] a, input logic o,
                        input int exp, input string name);
    start = 1'b1;
    A     = a;
    op    = o;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk({name, " busy"}, int'(busy), 1);
      chk({name, " nodone"}, int'(done), 0);
      tick();
    end
    chk({name, " done"}, int'(done), 1);
    chk({name, " idle"}, int'(busy), 0);
    chk({name, " result"}, int'(result), exp);
  endtask

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 1'b0, 32};
    vecs[1] = '{32'h0000_0001, 1'b1, 31};
    vecs[2] = '{32'h0000_0000, 1'b0, 0};
    vecs[3] = '{32'h1234_5678, 1'b0, 13};
    vecs[4] = '{32'hA5A5_A5A5, 1'b1, 16};
    vecs[5] = '{32'h8000_0000, 1'b1, 31};
    vecs[6] = '{32'h0000_0000, 1'b1, 32};
    vecs[7] = '{32'h0F0F_0F0F, 1'b0, 16};

    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    A     = '0;
    clr   = 1'b0;
    tick();
    tick();
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst result", int'(result), 0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].op, vecs[i].exp, $sformatf("vec%0d", i));
      tick();
      chk($sformatf("vec%0d pulse", i), int'(done), 0);
      chk($sformatf("vec%0d hold", i), int'(result), vecs[i].exp);
    end

    // second start while busy is ignored
    start = 1'b1; A = 32'h8040_2010; op = 1'b0;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; A = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("ign done", int'(done), 1);
    chk("ign result", int'(result), 4);
    tick();
    chk("ign single", int'(done), 0);
    chk("ign nobusy", int'(busy), 0);
    tick();
    chk("ign still idle", int'(busy), 0);
    chk("ign no 2nd done", int'(done), 0);

    // clr mid-run: no done, result kept; restart at t+3
    start = 1'b1; A = 32'h0F0F_0F0F; op = 1'b0;
    tick();
    start = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr busy", int'(busy), 0);
    chk("clr done", int'(done), 0);
    chk("clr result", int'(result), 4);
    run_op(32'h0F0F_0F0F, 1'b0, 16, "clr restart");
    tick();

    // clr in IDLE blocks start
    start = 1'b1; clr = 1'b1; A = 32'hFFFF_FFFF;
    tick();
    start = 1'b0; clr = 1'b0;
    chk("idle clr", int'(busy), 0);
    tick();

    // back-to-back: start in the done cycle
    run_op(32'h0000_00FF, 1'b0, 8, "b2b first");
    run_op(32'hF000_0000, 1'b1, 28, "b2b second");
    tick();
    chk("b2b pulse", int'(done), 0);

    // reset mid-run with a simultaneous start
    start = 1'b1; A = 32'h0000_FFFF; op = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1; start = 1'b1; A = 32'hFFFF_FFFF;
    tick();
    reset = 1'b0; start = 1'b0;
    chk("mrst busy", int'(busy), 0);
    chk("mrst done", int'(done), 0);
    chk("mrst result", int'(result), 0);
    tick();
    chk("mrst start dropped", int'(busy), 0);
    for (int k = 0; k < 5; k++) tick();
    chk("mrst no done", int'(done), 0);
    chk("mrst result kept", int'(result), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
